// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : State encodings and control-field codes for the multi-cycle
//            MIPS control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam logic [2:0] JT_NONE = 3'b000;
    localparam logic [2:0] JT_BEQ  = 3'b001;
    localparam logic [2:0] JT_J    = 3'b010;
    localparam logic [2:0] JT_JR   = 3'b011;

    localparam logic [1:0] PC_SEL_PC4  = 2'b00;
    localparam logic [1:0] PC_SEL_BR   = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP = 2'b10;
    localparam logic [1:0] PC_SEL_RS   = 2'b11;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_NPC  = 2'b10;

    // Reserved jump codes (1xx) behave as plain ALU/memory instructions.
    function automatic logic [2:0] jt_norm(input logic [2:0] jt);
        return jt[2] ? JT_NONE : jt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_fsm_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mc_wait_timer
// Purpose  : Memory-ack watchdog; expired pulses on the LIMIT-th waiting cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mc_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (clear)
            r_count <= '0;
        else if (enable)
            r_count <= r_count + CW'(1);
    end

    assign expired = enable && (r_count == CW'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer. Optional ack
//            watchdog enabled by MC_CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    input  logic [2:0]        dec_jump_type,
    input  logic              dec_we_dmem,
    input  logic              dec_we_regfile,
    input  logic              dec_is_load,
    input  logic              alu_zero,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              rf_we,
    output logic [1:0]        wb_sel,
    output logic              busy,
    output logic [2:0]        state,
    output logic [DWIDTH-1:0] retired_cnt,
    output logic              err
);
    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [DWIDTH-1:0] r_retired_cnt;
    logic              w_retire;
    logic [2:0]        w_jt;
    logic              w_timeout;

    assign w_jt = jt_norm(dec_jump_type);

    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_SEL_PC4;
        rf_we        = 1'b0;
        wb_sel       = WB_SEL_ALU;
        case (r_state)
            IDLE: begin
                if (start && !stop)
                    w_next_state = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we        = 1'b1;
                    pc_we        = 1'b1;
                    w_next_state = DECODE;
                end else if (w_timeout) begin
                    w_next_state = ERR;
                end
            end
            DECODE: w_next_state = EXEC;
            EXEC: begin
                case (w_jt)
                    JT_BEQ: begin
                        pc_we    = alu_zero;
                        pc_sel   = PC_SEL_BR;
                        w_retire = 1'b1;
                    end
                    JT_JR: begin
                        pc_we    = 1'b1;
                        pc_sel   = PC_SEL_RS;
                        w_retire = 1'b1;
                    end
                    JT_J: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_SEL_JUMP;
                        if (dec_we_regfile) w_next_state = WB;
                        else                w_retire     = 1'b1;
                    end
                    default: begin
                        if (dec_we_dmem || dec_is_load) w_next_state = MEM;
                        else if (dec_we_regfile)        w_next_state = WB;
                        else                            w_retire     = 1'b1;
                    end
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_we_dmem;
                // A store that is also flagged as a load never writes back.
                if (dmem_ack) begin
                    if (dec_we_dmem) w_retire     = 1'b1;
                    else             w_next_state = WB;
                end else if (w_timeout) begin
                    w_next_state = ERR;
                end
            end
            WB: begin
                rf_we    = 1'b1;
                w_retire = 1'b1;
                if (dec_is_load)       wb_sel = WB_SEL_LOAD;
                else if (w_jt == JT_J) wb_sel = WB_SEL_NPC;
                else                   wb_sel = WB_SEL_ALU;
            end
`ifdef MC_CTRL_TIMEOUT_EN
            ERR: w_next_state = ERR;
`endif
            default: w_next_state = IDLE;
        endcase
        if (w_retire)
            w_next_state = stop ? IDLE : FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_retired_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire)
                r_retired_cnt <= r_retired_cnt + DWIDTH'(1);
        end
    end

`ifdef MC_CTRL_TIMEOUT_EN
    logic w_wait_clear;

    assign w_wait_clear = !(imem_req || dmem_req)
                        || (imem_req && imem_ack) || (dmem_req && dmem_ack);

    mc_wait_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_wait_clear),
        .enable  (!w_wait_clear),
        .expired (w_timeout)
    );

    assign err = (r_state == ERR);
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYC > 0);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    assign busy        = (r_state != IDLE);
    assign state       = r_state;
    assign retired_cnt = r_retired_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Purpose  : Scoreboard bench for mc_ctrl_fsm (watchdog case under
//            MC_CTRL_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_ERR = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, imem_ack, dmem_ack;
    logic [2:0]  dec_jump_type;
    logic        dec_we_dmem, dec_we_regfile, dec_is_load, alu_zero;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, busy, err;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic [31:0] retired_cnt;

    mc_ctrl_fsm #(.DWIDTH(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .dec_jump_type(dec_jump_type), .dec_we_dmem(dec_we_dmem),
        .dec_we_regfile(dec_we_regfile), .dec_is_load(dec_is_load),
        .alu_zero(alu_zero), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .rf_we(rf_we), .wb_sel(wb_sel), .busy(busy), .state(state),
        .retired_cnt(retired_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [10:0] outs;
        logic [31:0] cnt;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt  = 0;
    logic        exp_err  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic ireq, dreq, dwe, irw, pcw,
                                       input logic [1:0] ps, input logic rf,
                                       input logic [1:0] ws, input logic b);
        return {ireq, dreq, dwe, irw, pcw, ps, rf, ws, b};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.tag, "_state"}, 32'(state), 32'(mon_e.st));
            check({mon_e.tag, "_outs"},
                  32'({imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel, busy}),
                  32'(mon_e.outs));
            check({mon_e.tag, "_cnt"}, retired_cnt, mon_e.cnt);
            check({mon_e.tag, "_err"}, 32'(err), 32'(mon_e.err));
        end
    end

    // Expected values for the current cycle; the monitor compares them at the
    // following falling edge, then inputs move on just after the rising edge.
    task automatic push_cycle(input string tag, input logic [2:0] st, input logic [10:0] outs);
        exp_t e;
        e.tag = tag; e.st = st; e.outs = outs; e.cnt = exp_cnt; e.err = exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // path: 0 retire in EXEC, 1 MEM then retire, 2 MEM then WB, 3 WB
    task automatic run_instr(input string name, input logic [2:0] jt,
                             input logic wd, wr, ld, z, input int fw, mw,
                             input logic epcwe, input logic [1:0] epsel,
                             input int path, input logic [1:0] ewb, input logic stp);
        dec_jump_type = jt; dec_we_dmem = wd; dec_we_regfile = wr;
        dec_is_load = ld; alu_zero = z; stop = 1'b0;
        for (int k = 0; k <= fw; k++) begin
            imem_ack = (k == fw);
            push_cycle({name, "_fetch"}, S_FETCH,
                       mk(1, 0, 0, k == fw, k == fw, 2'b00, 0, 2'b00, 1));
        end
        imem_ack = 1'b0;
        stop = stp;
        push_cycle({name, "_dec"}, S_DECODE, mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1));
        push_cycle({name, "_exec"}, S_EXEC, mk(0, 0, 0, 0, epcwe, epsel, 0, 2'b00, 1));
        if (path == 1 || path == 2) begin
            for (int k = 0; k <= mw; k++) begin
                dmem_ack = (k == mw);
                push_cycle({name, "_mem"}, S_MEM, mk(0, 1, wd, 0, 0, 2'b00, 0, 2'b00, 1));
            end
            dmem_ack = 1'b0;
        end
        if (path == 2 || path == 3)
            push_cycle({name, "_wb"}, S_WB, mk(0, 0, 0, 0, 0, 2'b00, 1, ewb, 1));
        exp_cnt++;
        stop = 1'b0;
    endtask

    task automatic kick(input string tag);
        start = 1'b1;
        push_cycle(tag, S_IDLE, 11'd0);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        dec_jump_type = 3'b000; dec_we_dmem = 1'b0; dec_we_regfile = 1'b0;
        dec_is_load = 1'b0; alu_zero = 1'b0;
        @(posedge clk);
        #1;
        push_cycle("reset", S_IDLE, 11'd0);
        rst_n = 1'b1;
        start = 1'b1; stop = 1'b1;
        push_cycle("idle_startstop", S_IDLE, 11'd0);
        start = 1'b0; stop = 1'b0;
        push_cycle("idle_hold", S_IDLE, 11'd0);
        kick("idle_start");

        //        name    jt      wd wr ld z  fw mw pcwe psel  path wb     stop
        run_instr("add",  3'b000, 0, 1, 0, 0, 2, 0, 0, 2'b00, 3, 2'b00, 0);
        run_instr("beqt", 3'b001, 0, 0, 0, 1, 0, 0, 1, 2'b01, 0, 2'b00, 0);
        run_instr("beqf", 3'b001, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0);
        run_instr("lw",   3'b000, 0, 1, 1, 0, 1, 2, 0, 2'b00, 2, 2'b01, 0);
        run_instr("sw",   3'b000, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0);
        run_instr("jal",  3'b010, 0, 1, 0, 0, 0, 0, 1, 2'b10, 3, 2'b10, 0);
        run_instr("jr",   3'b011, 0, 0, 0, 0, 0, 0, 1, 2'b11, 0, 2'b00, 0);
        run_instr("j",    3'b010, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0);
        run_instr("jt1xx",3'b110, 0, 1, 0, 1, 0, 0, 0, 2'b00, 3, 2'b00, 0);
        run_instr("stld", 3'b000, 1, 1, 1, 0, 0, 1, 0, 2'b00, 1, 2'b00, 0);
        run_instr("nop",  3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        run_instr("lwstp",3'b000, 0, 1, 1, 0, 0, 3, 0, 2'b00, 2, 2'b01, 1);
        push_cycle("stopped", S_IDLE, 11'd0);

        // Asynchronous reset in the middle of a data access.
        kick("restart");
        dec_jump_type = 3'b000; dec_we_dmem = 1'b0; dec_we_regfile = 1'b1; dec_is_load = 1'b1;
        imem_ack = 1'b1;
        push_cycle("rst_fetch", S_FETCH, mk(1, 0, 0, 1, 1, 2'b00, 0, 2'b00, 1));
        imem_ack = 1'b0;
        push_cycle("rst_dec", S_DECODE, mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1));
        push_cycle("rst_exec", S_EXEC, 11'd1);
        push_cycle("rst_mem", S_MEM, mk(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 1));
        #1;
        rst_n = 1'b0;
        exp_cnt = 0;
        push_cycle("rst_async", S_IDLE, 11'd0);
        rst_n = 1'b1;
        push_cycle("rst_after", S_IDLE, 11'd0);

`ifdef MC_CTRL_TIMEOUT_EN
        kick("to_start");
        for (int k = 0; k < 16; k++)
            push_cycle("to_wait", S_FETCH, mk(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1));
        exp_err = 1'b1;
        start = 1'b1;
        push_cycle("to_err", S_ERR, mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1));
        stop = 1'b1;
        push_cycle("to_held", S_ERR, mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1));
        start = 1'b0; stop = 1'b0;
        push_cycle("to_held2", S_ERR, mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1));
`endif

        @(posedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
